// File: rtl/micro_pkg.sv
// micro_pkg: shared types, state addresses, dispatch codes and control-word field positions.
package micro_pkg;
  localparam int AW = 4;
  localparam int DW = 16;
  typedef logic [AW-1:0] uaddr_t;
  typedef logic [DW-1:0] cword_t;
  localparam uaddr_t FETCH    = 4'd0;
  localparam uaddr_t DECODE   = 4'd1;
  localparam uaddr_t MEMADR   = 4'd2;
  localparam uaddr_t MEMREAD  = 4'd3;
  localparam uaddr_t MEMWB    = 4'd4;
  localparam uaddr_t MEMWRITE = 4'd5;
  localparam uaddr_t EXECUTER = 4'd6;
  localparam uaddr_t EXECUTEI = 4'd7;
  localparam uaddr_t ALUWB    = 4'd8;
  localparam uaddr_t BRANCH   = 4'd9;
  localparam uaddr_t DISP1    = 4'hF;
  localparam uaddr_t DISP2    = 4'hE;
  localparam int NEXTPC_B     = 15;
  localparam int REGW_B       = 14;
  localparam int MEMW_B       = 13;
  localparam int IRWRITE_B    = 12;
  localparam int ADRSRC_B     = 11;
  localparam int RESULTSRC_HI = 10;
  localparam int RESULTSRC_LO = 9;
  localparam int ALUSRCA_B    = 8;
  localparam int ALUSRCB_HI   = 7;
  localparam int ALUSRCB_LO   = 6;
  localparam int BRANCH_B     = 5;
  localparam int ALUOP_B      = 4;
  localparam int NEXTADR_HI   = 3;
endpackage

// File: rtl/micro_rom.sv
// micro_rom: combinational control store holding the default microprogram image.
module micro_rom
  import micro_pkg::*;
(
  input  uaddr_t addr,
  output cword_t word
);
  always_comb begin
    case (addr)
      FETCH:    word = 16'h9581;
      DECODE:   word = 16'h058F;
      MEMADR:   word = 16'h004E;
      MEMREAD:  word = 16'h0804;
      MEMWB:    word = 16'h4200;
      MEMWRITE: word = 16'h2800;
      EXECUTER: word = 16'h0018;
      EXECUTEI: word = 16'h0058;
      ALUWB:    word = 16'h4000;
      BRANCH:   word = 16'h0460;
      default:  word = 16'h0000;
    endcase
  end
endmodule

// File: rtl/micro_sequencer.sv
// micro_sequencer: uPC register, control-store read and next-address/dispatch selection.
module micro_sequencer
  import micro_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [1:0]    Op,
  input  logic [5:0]    Funct,
  output logic [DW-1:0] controlWord,
  output logic [AW-1:0] uPC,
  output logic          illegal
);
  cword_t rom_word;
  uaddr_t n, nxt, disp1_adr;
  logic   ill_nxt;
  micro_rom u_rom (.addr(uPC), .word(rom_word));
  // Outputs are blanked during reset so no architectural write can fire.
  assign controlWord = reset ? '0 : rom_word;
  assign n = rom_word[NEXTADR_HI:0];
  always_comb begin
    disp1_adr = Op == 2'b00 ? (Funct[5] ? EXECUTEI : EXECUTER) :
                Op == 2'b01 ? MEMADR :
                Op == 2'b10 ? BRANCH : FETCH;
    nxt       = n == DISP1 ? disp1_adr :
                n == DISP2 ? (Funct[0] ? MEMREAD : MEMWRITE) : n;
    ill_nxt   = n == DISP1 && Op == 2'b11;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      uPC     <= FETCH;
      illegal <= 1'b0;
    end else if (en) begin
      uPC     <= nxt;
      illegal <= ill_nxt;
    end
  end
endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: directed-vector bench for the micro-sequencer.
module tb_micro_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [1:0]  Op = 2'b00;
  logic [5:0]  Funct = 6'b0;
  logic [15:0] controlWord;
  logic [3:0]  uPC;
  logic        illegal;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] img [16];

  micro_sequencer dut (
    .clk(clk), .reset(reset), .en(en), .Op(Op), .Funct(Funct),
    .controlWord(controlWord), .uPC(uPC), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic adv(input string tag, input logic [3:0] eu);
    step();
    chk({tag, "_upc"}, {12'h0, uPC}, {12'h0, eu});
    chk({tag, "_cw"}, controlWord, img[eu]);
  endtask

  initial begin
    img = '{16'h9581, 16'h058F, 16'h004E, 16'h0804, 16'h4200, 16'h2800, 16'h0018, 16'h0058,
            16'h4000, 16'h0460, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    step();
    step();
    chk("rst_upc", {12'h0, uPC}, 16'h0);
    chk("rst_cw", controlWord, 16'h0000);
    chk("rst_ill", {15'h0, illegal}, 16'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_cw", controlWord, 16'h9581);
    en = 1'b1;
    // ADD register
    Op = 2'b00; Funct = 6'b000000;
    adv("add1", 4'd1); adv("add2", 4'd6); adv("add3", 4'd8); adv("add4", 4'd0);
    // ADD immediate
    Funct = 6'b100000;
    adv("addi1", 4'd1); adv("addi2", 4'd7); adv("addi3", 4'd8); adv("addi4", 4'd0);
    // LDR
    Op = 2'b01; Funct = 6'b000001;
    adv("ldr1", 4'd1); adv("ldr2", 4'd2); adv("ldr3", 4'd3);
    chk("ldr_memw", {15'h0, controlWord[13]}, 16'h0);
    adv("ldr4", 4'd4); adv("ldr5", 4'd0);
    // STR
    Funct = 6'b000000;
    adv("str1", 4'd1); adv("str2", 4'd2); adv("str3", 4'd5);
    chk("str_memw", {15'h0, controlWord[13]}, 16'h1);
    adv("str4", 4'd0);
    chk("str_memw0", {15'h0, controlWord[13]}, 16'h0);
    // Branch
    Op = 2'b10;
    adv("b1", 4'd1);
    chk("b_br0", {15'h0, controlWord[5]}, 16'h0);
    adv("b2", 4'd9);
    chk("b_br1", {15'h0, controlWord[5]}, 16'h1);
    adv("b3", 4'd0);
    // Undefined Op
    Op = 2'b11;
    adv("ill1", 4'd1);
    chk("ill_pre", {15'h0, illegal}, 16'h0);
    adv("ill2", 4'd0);
    chk("ill_pulse", {15'h0, illegal}, 16'h1);
    adv("ill3", 4'd1);
    chk("ill_clear", {15'h0, illegal}, 16'h0);
    // Stall at DECODE while Op toggles
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      Op = i[1:0];
      adv("stall", 4'd1);
    end
    Op = 2'b10;
    en = 1'b1;
    adv("stall_disp", 4'd9);
    Op = 2'b01;
    adv("stall_ret", 4'd0);
    // Async reset mid-LDR
    Op = 2'b01; Funct = 6'b000001;
    adv("mr1", 4'd1); adv("mr2", 4'd2); adv("mr3", 4'd3);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_upc", {12'h0, uPC}, 16'h0);
    chk("arst_cw", controlWord, 16'h0000);
    chk("arst_ill", {15'h0, illegal}, 16'h0);
    step();
    chk("arst_hold_cw", controlWord, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("arst_rel_cw", controlWord, 16'h9581);
    adv("arst_next", 4'd1);
    adv("arst_next2", 4'd2);
    // Backdoor stray address
    force dut.uPC = 4'd12;
    #1;
    chk("stray_cw", controlWord, 16'h0000);
    release dut.uPC;
    adv("stray_next", 4'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
- Upstream neighbour of the control-word field splitter in the microprogrammed multicycle ARM controller.
- Holds the micro-program counter (uPC) and reads a 16-entry x 16-bit control store at uPC.
- Drives the 16-bit control word to the splitter.
- Computes the next uPC from the word's nextAdr field, or dispatches on instruction Op/Funct when nextAdr holds a reserved dispatch code.

Parameters:
- AW, 4, micro-address width (control store depth 2**AW).
- DW, 16, control word width.
- DISP1, 4'hF, nextAdr code meaning "dispatch on Op/Funct[5]".
- DISP2, 4'hE, nextAdr code meaning "dispatch on Funct[0] (L bit)".

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  advance enable; 0 holds uPC (stall).
- Op  in  2  instruction Op field, valid while uPC = DECODE/MEMADR.
- Funct  in  6  instruction Funct field.
- controlWord  out  DW  current microinstruction to the field splitter.
- uPC  out  AW  current micro-address (debug/verification).
- illegal  out  1  one-cycle registered pulse on undefined Op dispatch.

Behaviour:
- Control word layout, bit 15 down to bit 0: NextPC, RegW, MemW, IRWrite, AdrSrc, ResultSrc[1:0], ALUSrcA, ALUSrcB[1:0], Branch, ALUOp, nextAdr[3:0].
- Reset, asynchronous and active-high:
  - uPC <= 0 and illegal <= 0 immediately.
  - controlWord forced to 16'h0000 while reset is high, so no PC/IR/Reg/Mem write occurs during reset.
  - After reset deasserts, controlWord = ROM[0] combinationally.
  - Reset in the middle of any microinstruction abandons it; the next cycle starts at FETCH.
- controlWord = ROM[uPC], combinational read, zero latency from uPC.
- Next-address selection, evaluated on each rising clk edge when en = 1, using n = ROM[uPC][3:0]:
  - n == DISP1:
    - Op=00, Funct[5]=0 -> 6 (EXECUTER).
    - Op=00, Funct[5]=1 -> 7 (EXECUTEI).
    - Op=01 -> 2 (MEMADR).
    - Op=10 -> 9 (BRANCH).
    - Op=11 -> 0 (FETCH), and illegal <= 1 for exactly one cycle.
  - n == DISP2: Funct[0]=1 -> 3 (MEMREAD); Funct[0]=0 -> 5 (MEMWRITE).
  - Otherwise uPC <= n.
- illegal <= 0 on every edge other than an Op=11 DISP1 dispatch.
- en = 0: uPC and illegal hold. controlWord remains ROM[uPC], so a stalled state re-presents its word each cycle.
- Dispatch inputs are sampled only at the edge leaving the dispatching state. Op/Funct values at any other time are ignored.
- Wrap-around: addresses 10–15 hold 16'h0000 (nextAdr = 0), so any stray uPC returns to FETCH in one step. Entries 14 and 15 are never executed as dispatch codes.
- Default image (hex, address: word -> next):
  - 0 FETCH: 9581 -> 1
  - 1 DECODE: 058F -> DISP1
  - 2 MEMADR: 004E -> DISP2
  - 3 MEMREAD: 0804 -> 4
  - 4 MEMWB: 4200 -> 0
  - 5 MEMWRITE: 2800 -> 0
  - 6 EXECUTER: 0018 -> 8
  - 7 EXECUTEI: 0058 -> 8
  - 8 ALUWB: 4000 -> 0
  - 9 BRANCH: 0460 -> 0
  - 10–15: 0000 -> 0
- Instruction latency: branch 3 cycles, data-processing 4, STR 4, LDR 5 (FETCH through final state, inclusive).

Decomposition:
- Shared package micro_pkg:
  - uaddr_t (logic [AW-1:0]) and cword_t (logic [DW-1:0]).
  - State address constants FETCH … BRANCH.
  - DISP1/DISP2 codes.
  - Field bit-position constants matching the layout above.
- One sub-module, micro_rom: combinational AW-in/DW-out control store holding the default image as a case table.
- Next-address mux and uPC register live in micro_sequencer.

Test Plan:
- Reset asserted mid-LDR (uPC=3) -> uPC=0 and controlWord=0000 immediately, asynchronous to clk; after release controlWord=9581.
- ADD register (Op=00, Funct=000000), en=1 -> uPC sequence 0,1,6,8,0; controlWord 9581,058F,0018,4000.
- LDR (Op=01, Funct[0]=1) -> uPC 0,1,2,3,4,0; STR (Funct[0]=0) -> 0,1,2,5,0; MemW=1 only at uPC=5.
- B (Op=10) -> uPC 0,1,9,0; Branch bit=1 only at uPC=9. Op=11 -> uPC 0,1,0 with illegal=1 for one cycle after the DECODE edge, otherwise 0.
- en held 0 for 3 cycles at uPC=1 while Op toggles -> uPC stays 1 and controlWord stays 058F; dispatch uses Op present at the first enabled edge.
- Force uPC to 12 (backdoor) -> controlWord=0000, next uPC=0.
